// File: rtl/xmem_pkg.sv
// xmem_pkg: state encoding and bus widths shared by the xmem arbiter, MIG wrapper and service processor.
package xmem_pkg;
   localparam int ADR_W = 30;
   localparam int DAT_W = 32;
   localparam int SEL_W = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} xmem_state_t;
endpackage

// File: rtl/xmem_timeout.sv
// xmem_timeout: ack watchdog for the granted slave access with a sticky timeout flag.
module xmem_timeout
   import xmem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic stb,
   input  logic ack,
   input  logic clr,
   output logic hit,
   output logic timeout_o
);
   localparam logic [15:0] LIM = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt;
   // hit lands on the TIMEOUT_CYCLES-th consecutive stalled cycle; an ack in that cycle wins
   assign hit = (TIMEOUT_CYCLES != 0) && stb && !ack && cnt == LIM;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt       <= '0;
         timeout_o <= 1'b0;
      end else begin
         cnt       <= (stb && !ack && !hit && !clr) ? cnt + 16'd1 : '0;
         timeout_o <= timeout_o | hit;
      end
endmodule

// File: rtl/xmem_arbiter.sv
// xmem_arbiter: two-master round-robin Wishbone arbiter for the external-memory port,
// locking the bus per cyc and aborting stalled accesses with err.
module xmem_arbiter
   import xmem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:ADR_W+1]   m0_adr_i,
   input  logic [0:DAT_W-1]   m0_dat_i,
   output logic [0:DAT_W-1]   m0_dat_o,
   input  logic               m0_we_i,
   input  logic               m0_stb_i,
   input  logic               m0_cyc_i,
   input  logic [0:SEL_W-1]   m0_sel_i,
   output logic               m0_ack_o,
   output logic               m0_err_o,
   input  logic [2:ADR_W+1]   m1_adr_i,
   input  logic [0:DAT_W-1]   m1_dat_i,
   output logic [0:DAT_W-1]   m1_dat_o,
   input  logic               m1_we_i,
   input  logic               m1_stb_i,
   input  logic               m1_cyc_i,
   input  logic [0:SEL_W-1]   m1_sel_i,
   output logic               m1_ack_o,
   output logic               m1_err_o,
   output logic [2:ADR_W+1]   s_adr_o,
   output logic [0:DAT_W-1]   s_dat_o,
   input  logic [0:DAT_W-1]   s_dat_i,
   output logic               s_we_o,
   output logic               s_stb_o,
   output logic               s_cyc_o,
   output logic [0:SEL_W-1]   s_sel_o,
   input  logic               s_ack_i,
   output logic [0:1]         grant_o,
   output logic               timeout_o
);
   xmem_state_t state, state_nxt, pick;
   logic last, prev, g0, g1, stb_g, hit;
   assign g0 = state == GNT0;
   assign g1 = state == GNT1;
   // while leaving a grant the exiting master counts as last, so a waiting peer wins
   assign prev = g0 ? 1'b0 : g1 ? 1'b1 : last;
   assign pick = (m0_cyc_i && m1_cyc_i) ? (prev ? GNT0 : GNT1) :
                 m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
   assign state_nxt = (g0 && m0_cyc_i) ? GNT0 : (g1 && m1_cyc_i) ? GNT1 : pick;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state != IDLE && state_nxt != state) last <= g1;
      end
   assign stb_g    = (g0 && m0_cyc_i && m0_stb_i) || (g1 && m1_cyc_i && m1_stb_i);
   assign s_cyc_o  = (g0 && m0_cyc_i) || (g1 && m1_cyc_i);
   assign s_stb_o  = stb_g && !hit;
   assign s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
   assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
   assign s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
   assign s_we_o   = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   // gating with s_stb_o drops stale acks that arrive with no strobe outstanding
   assign m0_ack_o = s_ack_i && s_stb_o && g0;
   assign m1_ack_o = s_ack_i && s_stb_o && g1;
   assign m0_err_o = hit && g0;
   assign m1_err_o = hit && g1;
   assign grant_o  = {g0, g1};
   xmem_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk(clk),
      .reset(reset),
      .stb(stb_g),
      .ack(s_ack_i),
      .clr(state_nxt != state),
      .hit(hit),
      .timeout_o(timeout_o)
   );
endmodule
